// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Shared definitions for the MIPS pipeline stages.
//   WORD_W      : datapath width
//   REG_IDX_W   : register-file index width
//   mem_state_t : load-latency FSM states of the memory stage
package mips_pipe_pkg;

  localparam int WORD_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// data_mem
// Word-addressed data memory: synchronous write port with write enable,
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable, wdata stored at addr on the clock edge
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : read data, follows addr combinationally
module data_mem
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_reg [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  assign rdata = mem_reg[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Memory-access stage of the 5-stage MIPS pipeline plus the MEM/WB register.
// Word loads/stores against an internal data_mem. Loads take LAT cycles;
// for LAT>1 a small FSM holds StallM high and sends bubbles to WB until the
// load completes. Stores always complete in one cycle.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned access detection,
// reported on AddrErrW; otherwise AddrErrW is tied 0).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   RegWriteM .. MEM_PCPlus4 : MEM-side control/data bundle from EX/MEM
//   StallM                 : combinational stall to the hazard unit
//   RegWriteW .. WB_PCPlus4 : registered WB-side bundle
//   AddrErrW               : misaligned access flag for the WB cycle
module mem_wb_stage
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWriteM,
  input  logic                 MemtoRegM,
  input  logic                 MemWriteM,
  input  logic                 MEM_Link,
  input  logic [REG_IDX_W-1:0] WriteRegM,
  input  logic [WORD_W-1:0]    MEM_ALUOut,
  input  logic [WORD_W-1:0]    MEM_WriteData,
  input  logic [WORD_W-1:0]    MEM_PCPlus4,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 WB_Link,
  output logic [REG_IDX_W-1:0] WriteRegW,
  output logic [WORD_W-1:0]    WB_ReadData,
  output logic [WORD_W-1:0]    WB_ALUOut,
  output logic [WORD_W-1:0]    WB_PCPlus4,
  output logic                 AddrErrW
);

  localparam bit         LAT_MULTI = (LAT > 1);
  localparam logic [2:0] CNT_INIT  = (LAT > 1) ? 3'(LAT - 2) : 3'd0;

  mem_state_t        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              is_load;
  logic              misalign;
  logic              start_busy;
  logic              stall_raw;
  logic              mem_we;
  logic [WORD_W-1:0] rdata;
  logic [ADDR_W-1:0] index;

  assign index = MEM_ALUOut[ADDR_W+1:2];

  // Byte-offset bits (when unchecked) and bits above the array are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{MEM_ALUOut[WORD_W-1:ADDR_W+2], MEM_ALUOut[1:0]};

  // Store wins when MemWriteM and MemtoRegM are both set.
  assign is_load = MemtoRegM & ~MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (MemtoRegM | MemWriteM) & (MEM_ALUOut[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A misaligned load completes immediately, so it never starts the wait.
  assign start_busy = LAT_MULTI & is_load & ~misalign;
  assign mem_we     = MemWriteM & ~misalign & ~reset;

  data_mem #(.ADDR_W(ADDR_W)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (index),
    .wdata (MEM_WriteData),
    .rdata (rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_busy) begin
          state_next = BUSY;
          cnt_next   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Output logic: stall_raw also selects bubble vs. capture for WB.
  always_comb begin
    stall_raw = 1'b0;
    case (state_reg)
      IDLE:    stall_raw = start_busy;
      BUSY:    stall_raw = (cnt_reg != 3'd0);
      default: stall_raw = 1'b0;
    endcase
  end

  assign StallM = stall_raw & ~reset;

  // MEM/WB register. A bubble clears only the control bits; data holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      WB_Link     <= 1'b0;
      WriteRegW   <= '0;
      WB_ReadData <= '0;
      WB_ALUOut   <= '0;
      WB_PCPlus4  <= '0;
      AddrErrW    <= 1'b0;
    end else if (stall_raw) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WB_Link   <= 1'b0;
      AddrErrW  <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~misalign;
      MemtoRegW   <= is_load;
      WB_Link     <= MEM_Link;
      WriteRegW   <= WriteRegM;
      WB_ReadData <= rdata;
      WB_ALUOut   <= MEM_ALUOut;
      WB_PCPlus4  <= MEM_PCPlus4;
      AddrErrW    <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Directed bench driving three mem_wb_stage instances (LAT = 1, 3, 4) from a
// shared input bundle; each instance's outputs are compared against
// hand-computed values.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemtoRegM, MemWriteM, MEM_Link;
  logic [4:0]  WriteRegM;
  logic [31:0] MEM_ALUOut, MEM_WriteData, MEM_PCPlus4;

  logic        stall_o [3];
  logic        rw_o    [3];
  logic        m2r_o   [3];
  logic        link_o  [3];
  logic        aerr_o  [3];
  logic [4:0]  wr_o    [3];
  logic [31:0] rd_o    [3];
  logic [31:0] alu_o   [3];
  logic [31:0] pc4_o   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instance 0: LAT=1, instance 1: LAT=3, instance 2: LAT=4
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_wb_stage #(
      .ADDR_W (10),
      .LAT    ((gi == 0) ? 1 : (gi == 1) ? 3 : 4)
    ) dut (
      .clk           (clk),
      .reset         (reset),
      .RegWriteM     (RegWriteM),
      .MemtoRegM     (MemtoRegM),
      .MemWriteM     (MemWriteM),
      .MEM_Link      (MEM_Link),
      .WriteRegM     (WriteRegM),
      .MEM_ALUOut    (MEM_ALUOut),
      .MEM_WriteData (MEM_WriteData),
      .MEM_PCPlus4   (MEM_PCPlus4),
      .StallM        (stall_o[gi]),
      .RegWriteW     (rw_o[gi]),
      .MemtoRegW     (m2r_o[gi]),
      .WB_Link       (link_o[gi]),
      .WriteRegW     (wr_o[gi]),
      .WB_ReadData   (rd_o[gi]),
      .WB_ALUOut     (alu_o[gi]),
      .WB_PCPlus4    (pc4_o[gi]),
      .AddrErrW      (aerr_o[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic mw, input logic lk,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4);
    RegWriteM     = rw;
    MemtoRegM     = m2r;
    MemWriteM     = mw;
    MEM_Link      = lk;
    WriteRegM     = wr;
    MEM_ALUOut    = alu;
    MEM_WriteData = wd;
    MEM_PCPlus4   = pc4;
    $display("t=%0t drive rw=%0d m2r=%0d mw=%0d lk=%0d wr=%0d alu=0x%08h wd=0x%08h pc4=0x%08h",
             $time, rw, m2r, mw, lk, wr, alu, wd, pc4);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_stall%0d", tag, i), {31'd0, stall_o[i]}, 32'd0);
      check($sformatf("%s_rw%0d", tag, i),    {31'd0, rw_o[i]},    32'd0);
      check($sformatf("%s_m2r%0d", tag, i),   {31'd0, m2r_o[i]},   32'd0);
      check($sformatf("%s_link%0d", tag, i),  {31'd0, link_o[i]},  32'd0);
      check($sformatf("%s_aerr%0d", tag, i),  {31'd0, aerr_o[i]},  32'd0);
      check($sformatf("%s_wr%0d", tag, i),    {27'd0, wr_o[i]},    32'd0);
      check($sformatf("%s_rd%0d", tag, i),    rd_o[i],             32'd0);
      check($sformatf("%s_alu%0d", tag, i),   alu_o[i],            32'd0);
      check($sformatf("%s_pc4%0d", tag, i),   pc4_o[i],            32'd0);
    end
  endtask

  initial begin
    // Reset held 2 cycles with a load sitting on the inputs.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h10, 32'h0, 32'h0);
    step();
    step();
    check_reset_state("rst0");

    reset = 1'b0;
    nop();
    step();

    // Store DEADBEEF to 0x10.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h0);
    #1 check("st_stall_l3", {31'd0, stall_o[1]}, 32'd0);
    step();

    // Load 0x10 -> r8, held until every instance has completed it.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h10, 32'h0, 32'h0);
    #1;
    check("ld_stall0_l1", {31'd0, stall_o[0]}, 32'd0);
    check("ld_stall0_l3", {31'd0, stall_o[1]}, 32'd1);
    check("ld_stall0_l4", {31'd0, stall_o[2]}, 32'd1);
    step();
    check("ld_rd_l1",     rd_o[0], 32'hDEADBEEF);
    check("ld_m2r_l1",    {31'd0, m2r_o[0]}, 32'd1);
    check("ld_rw_l1",     {31'd0, rw_o[0]},  32'd1);
    check("ld_wr_l1",     {27'd0, wr_o[0]},  32'd8);
    check("ld_stall1_l3", {31'd0, stall_o[1]}, 32'd1);
    check("ld_bub1_l3",   {31'd0, rw_o[1]},    32'd0);
    step();
    check("ld_stall2_l3", {31'd0, stall_o[1]}, 32'd0);
    check("ld_bub2_l3",   {31'd0, rw_o[1]},    32'd0);
    check("ld_stall2_l4", {31'd0, stall_o[2]}, 32'd1);
    step();
    check("ld_rd_l3",     rd_o[1], 32'hDEADBEEF);
    check("ld_rw_l3",     {31'd0, rw_o[1]},  32'd1);
    check("ld_m2r_l3",    {31'd0, m2r_o[1]}, 32'd1);
    check("ld_wr_l3",     {27'd0, wr_o[1]},  32'd8);
    check("b2b_stall_l3", {31'd0, stall_o[1]}, 32'd1);
    check("ld_stall3_l4", {31'd0, stall_o[2]}, 32'd0);
    step();
    check("ld_rd_l4",     rd_o[2], 32'hDEADBEEF);
    check("ld_rw_l4",     {31'd0, rw_o[2]}, 32'd1);

    // Non-memory op with link, observed on the LAT=1 instance.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 32'h1234, 32'h0, 32'h40);
    #1 check("alu_stall_l1", {31'd0, stall_o[0]}, 32'd0);
    step();
    check("alu_alu_l1",  alu_o[0], 32'h1234);
    check("alu_link_l1", {31'd0, link_o[0]}, 32'd1);
    check("alu_pc4_l1",  pc4_o[0], 32'h40);
    check("alu_m2r_l1",  {31'd0, m2r_o[0]}, 32'd0);
    check("alu_rw_l1",   {31'd0, rw_o[0]},  32'd1);

    // Clean restart before the reset-abort case.
    reset = 1'b1;
    nop();
    step();
    reset = 1'b0;
    step();

    // LAT=4 load aborted by reset in its second stall cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h10, 32'h0, 32'h0);
    #1 check("abort_stall1_l4", {31'd0, stall_o[2]}, 32'd1);
    step();
    check("abort_stall2_l4", {31'd0, stall_o[2]}, 32'd1);
    check("abort_bub_l4",    {31'd0, rw_o[2]},    32'd0);
    reset = 1'b1;
    #1 check("abort_rst_stall_l4", {31'd0, stall_o[2]}, 32'd0);
    step();
    step();
    check_reset_state("rst1");
    reset = 1'b0;
    nop();
    #1 check("abort_idle_stall_l4", {31'd0, stall_o[2]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("abort_nowb%0d_l4", k), {31'd0, rw_o[2]}, 32'd0);
      check($sformatf("abort_nostall%0d_l4", k), {31'd0, stall_o[2]}, 32'd0);
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned store must not touch word 4.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h12, 32'h5, 32'h0);
    step();
    check("mis_st_aerr_l1", {31'd0, aerr_o[0]}, 32'd1);
    // Misaligned load on LAT=3: no stall, no register write.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h11, 32'h0, 32'h0);
    #1 check("mis_ld_stall_l3", {31'd0, stall_o[1]}, 32'd0);
    step();
    check("mis_ld_rw_l3",     {31'd0, rw_o[1]},    32'd0);
    check("mis_ld_aerr_l3",   {31'd0, aerr_o[1]},  32'd1);
    check("mis_ld_stall2_l3", {31'd0, stall_o[1]}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h10, 32'h0, 32'h0);
    step();
    check("mis_word4_l1", rd_o[0], 32'hDEADBEEF);
    check("al_aerr_l1",   {31'd0, aerr_o[0]}, 32'd0);
`else
    // Without checking, offset bits are ignored: 0x12 maps to word 4.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h12, 32'h5, 32'h0);
    step();
    check("noal_st_aerr_l1", {31'd0, aerr_o[0]}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h10, 32'h0, 32'h0);
    step();
    check("noal_word4_l1", rd_o[0], 32'h5);
    check("noal_ld_rw_l1", {31'd0, rw_o[0]}, 32'd1);
`endif

    nop();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
